fir_transposed_mac_param: RTL
=============================

Name: fir_transposed_mac_param

Overview:
- Parametrised transposed-form FIR MAC engine: the next generation of the fixed 10-tap, 16-bit filter.
- Generalises data, coefficient and accumulator widths and tap count.
- Adds an internal coefficient register bank with a write port, and a full-width cascade in/out so multiple blocks can be chained.
- Adds output scaling, and a run/flush state machine that drains the pipeline with zeros. It sits after the sample-rate strobe generator in the 12 MHz domain.

Parameters:
DATA_W, 3, signed input sample width
COEF_W, 16, signed coefficient width
TAPS, 10, number of taps (>=2)
ACC_W, 24, accumulator / cascade width (must be >= DATA_W+COEF_W+clog2(TAPS)+1)
OUT_W, 16, output width
OUT_SHIFT, 0, arithmetic right shift applied before output narrowing

Ports:
iClk_12M  in  1  system clock, rising edge
iRsn  in  1  asynchronous active-low reset
iEnSample_300k  in  1  sample strobe, one-cycle pulse
iRun  in  1  level; enables filtering
iFlush  in  1  one-cycle pulse; request pipeline drain
iClear  in  1  one-cycle pulse; synchronous clear of datapath
iCoefWr  in  1  coefficient write strobe
iCoefAddr  in  clog2(TAPS)  coefficient index
iCoefData  in  COEF_W  signed coefficient value
iFirIn  in  DATA_W  signed sample
iCascade  in  ACC_W  signed cascade input (tie 0 if unused)
oMac  out  OUT_W  signed filtered output
oValid  out  1  one-cycle pulse when oMac updates
oCascade  out  ACC_W  full-width last accumulator stage
oBusy  out  1  state != IDLE
oFlushDone  out  1  one-cycle pulse at end of flush

Behaviour:
- Reset (async, iRsn=0): every coefficient, every rAcc stage, oMac, oValid, oFlushDone = 0; state = IDLE.
- Coefficient bank: c[0..TAPS-1].
  - Written on the clock where iCoefWr=1, in any state.
  - iCoefAddr >= TAPS is ignored.
  - A write coincident with a strobe takes effect after that strobe; the strobe uses the old value.
- Products: p[k] = iFirIn * c[k], full signed DATA_W+COEF_W product, sign-extended to ACC_W.
- Chain update on an accepted strobe: rAcc[0] <= iCascade + p[0]; rAcc[k] <= rAcc[k-1] + p[k] for k=1..TAPS-1; oMac <= narrow(rAcc[TAPS-1]); oValid <= 1.
- Accumulator adds wrap at ACC_W. Sizing rule on ACC_W prevents overflow.
- Transfer: y[n] = iCascade[n-TAPS] + sum_k c[TAPS-1-k]*x[n-1-k]. Latency is one strobe from input to first contribution at oMac.
- narrow(): arithmetic shift right by OUT_SHIFT, then reduce to OUT_W (wrap or saturate, see Optional Feature).
- oCascade = rAcc[TAPS-1], combinational from the register.
- FSM states:
  - IDLE: strobes ignored, chain holds, oValid=0. iRun=1 -> RUN.
  - RUN: strobes accepted with live iFirIn/iCascade. iFlush -> FLUSH (priority over iRun=0). Otherwise iRun=0 -> IDLE.
  - FLUSH: strobes accepted with iFirIn and iCascade forced to 0. A counter counts TAPS accepted strobes; on the TAPS-th strobe -> IDLE and oFlushDone=1 for one cycle. iRun and iFlush are ignored in FLUSH.
- iClear (any state, highest priority after reset): rAcc[*], oMac, flush counter = 0; state -> IDLE; oValid=0 that cycle; coefficients retained.
- Strobe in the same cycle as a state transition is handled under the state current in that cycle.
- Async reset mid-operation aborts immediately; no partial flush completion pulse.

Optional Feature:
- Macro FIR_OUT_SAT_EN.
- Defined: narrow() saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: narrow() keeps the low OUT_W bits (two's-complement wrap).
- The ACC_W chain is unaffected either way.

Test Plan:
- Impulse: defaults, c[i]=i+1, RUN, x=+1 on one strobe then 0 -> oMac on the next 10 strobes = 10,9,...,1, then 0; oValid pulses with each.
- Steady state: all c=0x7FFF, x=-4 constant, 11+ strobes.
  - FIR_OUT_SAT_EN defined -> oMac settles at -32768.
  - Undefined -> oMac = 0x0028.
  - oCascade = -1310680 in both cases.
- Flush: after the impulse run, pulse iFlush -> oBusy stays 1 for exactly 10 strobes; oFlushDone pulses on the 10th; chain = 0; state IDLE.
- Cascade: c all 0, iCascade=1000 on one strobe -> oMac=1000 exactly TAPS strobes later; oCascade=1000 one strobe earlier.
- Coefficient write: write c[3]=5 in the same cycle as a strobe -> that strobe uses the old c[3]; iCoefAddr=12 write -> no change.
- Clear/reset: iClear mid-RUN -> oMac=0, state IDLE, coefficients intact. Drop iRsn mid-FLUSH -> all outputs 0 asynchronously, no oFlushDone.

Source files
------------

// File: rtl/fir_transposed_mac_param.sv
// Purpose: parametrised transposed-form FIR MAC with coefficient bank, cascade in/out, output narrowing and run/flush FSM.
// Latency: one accepted strobe from iFirIn to first contribution at oMac; oCascade is the last chain register.
// Backpressure: none; every strobe in RUN/FLUSH is consumed, strobes in IDLE are dropped.
//
// Ports: iClk_12M/iRsn clock and async active-low reset; iEnSample_300k sample strobe;
//        iRun/iFlush/iClear control; iCoefWr/iCoefAddr/iCoefData coefficient write port;
//        iFirIn sample, iCascade upstream chain input; oMac/oValid narrowed output and update pulse;
//        oCascade full-width last stage; oBusy state != IDLE; oFlushDone end-of-flush pulse.
// Build option: define FIR_OUT_SAT_EN to saturate oMac instead of wrapping to OUT_W bits.
module fir_transposed_mac_param #(
    parameter int DATA_W    = 3,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 10,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       iClk_12M,
    input  logic                       iRsn,
    input  logic                       iEnSample_300k,
    input  logic                       iRun,
    input  logic                       iFlush,
    input  logic                       iClear,
    input  logic                       iCoefWr,
    input  logic [$clog2(TAPS)-1:0]    iCoefAddr,
    input  logic signed [COEF_W-1:0]   iCoefData,
    input  logic signed [DATA_W-1:0]   iFirIn,
    input  logic signed [ACC_W-1:0]    iCascade,
    output logic signed [OUT_W-1:0]    oMac,
    output logic                       oValid,
    output logic signed [ACC_W-1:0]    oCascade,
    output logic                       oBusy,
    output logic                       oFlushDone
);

    localparam int PW = DATA_W + COEF_W;
    localparam int CW = $clog2(TAPS);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             flush_cnt;
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [ACC_W-1:0]   acc  [TAPS];
    logic signed [ACC_W-1:0]   prod [TAPS];
    logic signed [DATA_W-1:0]  x_eff;
    logic signed [ACC_W-1:0]   casc_eff;
    logic signed [OUT_W-1:0]   mac_nxt;
    logic                      accept;
    logic                      flush_last;

    assign accept     = iEnSample_300k && (state != S_IDLE);
    assign flush_last = (flush_cnt == FLUSH_LAST);

    // During a drain the chain is fed zeros so it empties toward the output.
    assign x_eff    = (state == S_FLUSH) ? '0 : iFirIn;
    assign casc_eff = (state == S_FLUSH) ? '0 : iCascade;

    // Full-precision signed products, sign-extended into the accumulator width.
    for (genvar k = 0; k < TAPS; k++) begin : g_prod
        logic signed [PW-1:0] p;
        assign p = $signed({{COEF_W{x_eff[DATA_W-1]}}, x_eff})
                 * $signed({{DATA_W{coef[k][COEF_W-1]}}, coef[k]});
        assign prod[k] = {{(ACC_W-PW){p[PW-1]}}, p};
    end

`ifdef FIR_OUT_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    always_comb begin
        shifted = acc[TAPS-1] >>> OUT_SHIFT;
        // In range when every bit from the output sign bit upward agrees.
        if ((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]))
            mac_nxt = shifted[OUT_W-1:0];
        else if (shifted[ACC_W-1])
            mac_nxt = {1'b1, {(OUT_W-1){1'b0}}};
        else
            mac_nxt = {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    assign mac_nxt = OUT_W'(acc[TAPS-1] >>> OUT_SHIFT);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (iRun) state_nxt = S_RUN;
            S_RUN: begin
                if (iFlush)     state_nxt = S_FLUSH;
                else if (!iRun) state_nxt = S_IDLE;
            end
            S_FLUSH: if (accept && flush_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (iClear) state_nxt = S_IDLE;
    end

    // Coefficient bank: writes land after any coincident strobe has used the old value.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
        end else if (iCoefWr && (32'(iCoefAddr) < TAPS)) begin
            coef[iCoefAddr] <= iCoefData;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state      <= S_IDLE;
            flush_cnt  <= '0;
            oMac       <= '0;
            oValid     <= 1'b0;
            oFlushDone <= 1'b0;
            for (int k = 0; k < TAPS; k++) acc[k] <= '0;
        end else begin
            state      <= state_nxt;
            oValid     <= 1'b0;
            oFlushDone <= 1'b0;
            if (iClear) begin
                flush_cnt <= '0;
                oMac      <= '0;
                for (int k = 0; k < TAPS; k++) acc[k] <= '0;
            end else if (accept) begin
                acc[0] <= casc_eff + prod[0];
                for (int k = 1; k < TAPS; k++) acc[k] <= acc[k-1] + prod[k];
                oMac   <= mac_nxt;
                oValid <= 1'b1;
                if (state == S_FLUSH) begin
                    flush_cnt  <= flush_last ? '0 : flush_cnt + CW'(1);
                    oFlushDone <= flush_last;
                end
            end
        end
    end

    assign oCascade = acc[TAPS-1];
    assign oBusy    = (state != S_IDLE);

endmodule
